// File: rtl/regfile_cmd_decoder_if.sv
// Host byte streams and register-file access bus of the command decoder.
//
// Handshake rule for both byte streams (rx and tx): the producer raises
// *_valid with *_data and keeps both stable. The consumer raises *_ready
// when it can take a byte. A byte transfers on a rising clk edge where
// valid && ready. The register-file side uses single-cycle read/write
// strobes. A read is answered by a single-cycle done pulse that carries
// read_data.
interface regfile_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       read;
  logic       write;
  logic [7:0] address;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       done;

  // Decoder side.
  modport slave (
    input  rx_data, rx_valid, tx_ready, read_data, done,
    output rx_ready, tx_data, tx_valid, read, write, address, write_data
  );

  // Host / register-file side.
  modport master (
    output rx_data, rx_valid, tx_ready, read_data, done,
    input  rx_ready, tx_data, tx_valid, read, write, address, write_data
  );
endinterface

// File: rtl/regfile_cmd_decoder.sv
// Byte-stream command decoder driving a simple register-file bus.
// A command is opcode, start address and length (0 means 256).
// Writes consume the data bytes that follow the header. Reads return one
// response byte per register-file read. A read that gets no done within
// TIMEOUT_CYCLES returns TIMEOUT_BYTE and pulses err.
module regfile_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  TIMEOUT_BYTE   = 8'hEE
) (
  input  logic                        clk,
  input  logic                        res_n,
  regfile_cmd_decoder_if.slave        bus,
  output logic                        busy,
  output logic                        err,
  output logic [2:0]                  state_dbg,
  output logic [8:0]                  cnt_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_WDATA = 3'd3,
    S_WSTRB = 3'd4,
    S_RSTRB = 3'd5,
    S_RWAIT = 3'd6,
    S_RSEND = 3'd7
  } state_t;

  // The timeout counter runs 0 .. TIMEOUT_CYCLES-1 across the RWAIT cycles.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic          rdy_en;      // keeps rx_ready low until the first clock after reset
  logic          is_rd;       // current command is a read
  logic          incr;        // advance address after each access
  logic [8:0]    cnt;         // accesses still to perform
  logic [TW-1:0] tmo;
  logic [7:0]    address_q;
  logic [7:0]    write_data_q;
  logic [7:0]    tx_data_q;

  logic          rx_ready_c;
  logic          rx_fire;
  logic          op_legal;
  logic          last_access;
  logic          timeout_hit;
  logic          err_c;

  assign rx_ready_c  = rdy_en && ((state == S_IDLE) || (state == S_ADDR) ||
                                  (state == S_LEN)  || (state == S_WDATA));
  assign rx_fire     = bus.rx_valid && rx_ready_c;
  assign op_legal    = (bus.rx_data[7:6] == 2'b01) || (bus.rx_data[7:6] == 2'b10);
  assign last_access = (cnt == 9'd1);
  assign timeout_hit = (state == S_RWAIT) && !bus.done && (tmo == TMO_LAST);

  assign bus.rx_ready   = rx_ready_c;
  assign bus.tx_valid   = (state == S_RSEND);
  assign bus.tx_data    = tx_data_q;
  assign bus.read       = (state == S_RSTRB);
  assign bus.write      = (state == S_WSTRB);
  assign bus.address    = address_q;
  assign bus.write_data = write_data_q;
  assign busy           = (state != S_IDLE);
  assign err            = err_c;
  assign state_dbg      = state;
  assign cnt_dbg        = cnt;

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and the err pulse.
  always_comb begin
    state_nx = state;
    err_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_fire) begin
          if (op_legal) state_nx = S_ADDR;
          else          err_c    = 1'b1;
        end
      end
      S_ADDR: begin
        if (rx_fire) state_nx = S_LEN;
      end
      S_LEN: begin
        if (rx_fire) state_nx = is_rd ? S_RSTRB : S_WDATA;
      end
      S_WDATA: begin
        if (rx_fire) state_nx = S_WSTRB;
      end
      S_WSTRB: begin
        state_nx = last_access ? S_IDLE : S_WDATA;
      end
      S_RSTRB: begin
        state_nx = S_RWAIT;
      end
      S_RWAIT: begin
        if (bus.done) begin
          state_nx = S_RSEND;
        end else if (timeout_hit) begin
          err_c    = 1'b1;
          state_nx = S_RSEND;
        end
      end
      S_RSEND: begin
        if (bus.tx_ready) state_nx = last_access ? S_IDLE : S_RSTRB;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command fields, access counter, address and data registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rdy_en       <= 1'b0;
      is_rd        <= 1'b0;
      incr         <= 1'b0;
      cnt          <= 9'd0;
      tmo          <= '0;
      address_q    <= 8'h00;
      write_data_q <= 8'h00;
      tx_data_q    <= 8'h00;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rx_fire && op_legal) begin
            is_rd <= bus.rx_data[7];
            incr  <= bus.rx_data[0];
          end
        end
        S_ADDR: begin
          if (rx_fire) address_q <= bus.rx_data;
        end
        S_LEN: begin
          if (rx_fire) cnt <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
        end
        S_WDATA: begin
          if (rx_fire) write_data_q <= bus.rx_data;
        end
        S_WSTRB: begin
          cnt <= cnt - 9'd1;
          if (incr) address_q <= address_q + 8'd1;
        end
        S_RSTRB: begin
          tmo <= '0;
        end
        S_RWAIT: begin
          if (bus.done) begin
            tx_data_q <= bus.read_data;
          end else if (tmo == TMO_LAST) begin
            tx_data_q <= TIMEOUT_BYTE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_RSEND: begin
          if (bus.tx_ready) begin
            cnt <= cnt - 9'd1;
            if (incr) address_q <= address_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_cmd_decoder.sv
// Directed bench for regfile_cmd_decoder: stimulus pushes expected strobes,
// response bytes and err pulses into queues; a monitor pops and compares
// whenever the DUT presents them.
module tb_regfile_cmd_decoder;

  logic       clk;
  logic       res_n;
  logic       busy;
  logic       err;
  logic [2:0] state_dbg;
  logic [8:0] cnt_dbg;

  regfile_cmd_decoder_if bus ();

  regfile_cmd_decoder #(
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_BYTE  (8'hEE)
  ) dut (
    .clk      (clk),
    .res_n    (res_n),
    .bus      (bus),
    .busy     (busy),
    .err      (err),
    .state_dbg(state_dbg),
    .cnt_dbg  (cnt_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_wr_q[$];   // {address, write_data}
  logic [7:0]  exp_rd_q[$];   // read address
  logic [7:0]  exp_tx_q[$];   // response byte
  logic [7:0]  exp_err_q[$];  // 0: illegal opcode, else cycles after read strobe
  logic [7:0]  rd_src_q[$];   // register-file model data

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_wr_cyc = -1;
  int last_rd_cyc = -1;
  int rd_cnt   = 0;
  bit rf_respond = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- register-file model ----------------
  // done answers one cycle after each read strobe.
  initial begin
    bit done_next;
    done_next     = 1'b0;
    bus.done      = 1'b0;
    bus.read_data = 8'h00;
    forever begin
      @(negedge clk);
      if (done_next) begin
        bus.done = 1'b1;
        if (rd_src_q.size() > 0) bus.read_data = rd_src_q.pop_front();
        else                     bus.read_data = 8'h00;
        done_next = 1'b0;
      end else begin
        bus.done = 1'b0;
      end
      if (bus.read && rf_respond && res_n) done_next = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [15:0] ew;
    logic [7:0]  eb;
    bit          prev_hold;
    logic [7:0]  prev_data;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!res_n) begin
        prev_hold = 1'b0;
      end else begin
        if (bus.write) begin
          if (exp_wr_q.size() == 0) begin
            check("wr_unexpected", {bus.address, bus.write_data}, 32'hFFFF_FFFF);
          end else begin
            ew = exp_wr_q.pop_front();
            check("wr_pulse", {bus.address, bus.write_data}, ew);
          end
          if (last_wr_cyc >= 0) check("wr_spacing_ok", (cyc - last_wr_cyc) >= 2, 1);
          check("rd_wr_exclusive", bus.read, 0);
          last_wr_cyc = cyc;
        end
        if (bus.read) begin
          rd_cnt++;
          if (exp_rd_q.size() == 0) begin
            check("rd_unexpected", bus.address, 32'hFFFF_FFFF);
          end else begin
            eb = exp_rd_q.pop_front();
            check("rd_pulse_addr", bus.address, eb);
          end
          check("rd_while_tx_pending", bus.tx_valid, 0);
          last_rd_cyc = cyc;
        end
        if (bus.tx_valid && prev_hold) check("tx_stable", bus.tx_data, prev_data);
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_tx_q.size() == 0) begin
            check("tx_unexpected", bus.tx_data, 32'hFFFF_FFFF);
          end else begin
            eb = exp_tx_q.pop_front();
            check("tx_byte", bus.tx_data, eb);
          end
        end
        prev_hold = bus.tx_valid && !bus.tx_ready;
        prev_data = bus.tx_data;
        if (err) begin
          if (exp_err_q.size() == 0) begin
            check("err_unexpected", 1, 0);
          end else begin
            eb = exp_err_q.pop_front();
            if (eb != 8'd0) check("err_timeout_delay", cyc - last_rd_cyc, eb);
            else            check("err_illegal_idle", busy, 0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.rx_ready) check("rx_accept_timeout", 0, 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, bus.rx_ready, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_tx_valid"}, bus.tx_valid, 0);
    check({tag, "_rw"},       {bus.read, bus.write}, 0);
    check({tag, "_err"},      err, 0);
    check({tag, "_regs"},     {bus.address, bus.write_data, bus.tx_data}, 0);
    check({tag, "_cnt"},      cnt_dbg, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic [7:0] a;
    logic [7:0] d;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    res_n        = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", bus.rx_ready, 1);

    // Incrementing write of two bytes.
    exp_wr_q.push_back({8'h10, 8'hAA});
    exp_wr_q.push_back({8'h11, 8'hBB});
    send_byte(8'h41);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("wr2_last_strobe", bus.write, 1);
    @(negedge clk);
    check("wr2_busy_falls", busy, 0);

    // Burst read from a FIFO register (address fixed).
    rd_src_q = '{8'h01, 8'h02, 8'h03};
    exp_rd_q = '{8'h18, 8'h18, 8'h18};
    exp_tx_q = '{8'h01, 8'h02, 8'h03};
    send_byte(8'h80);
    send_byte(8'h18);
    send_byte(8'h03);
    wait_idle("fifo_read_idle", 200);

    // Same read under tx backpressure.
    rd_src_q = '{8'h01, 8'h02, 8'h03};
    exp_rd_q = '{8'h18, 8'h18, 8'h18};
    exp_tx_q = '{8'h01, 8'h02, 8'h03};
    bus.tx_ready = 1'b0;
    base = rd_cnt;
    send_byte(8'h80);
    send_byte(8'h18);
    send_byte(8'h03);
    repeat (20) @(negedge clk);
    check("bp_single_read", rd_cnt - base, 1);
    check("bp_tx_valid_held", bus.tx_valid, 1);
    check("bp_tx_data", bus.tx_data, 8'h01);
    bus.tx_ready = 1'b1;
    wait_idle("bp_read_idle", 200);
    check("bp_total_reads", rd_cnt - base, 3);

    // Read timeout.
    rf_respond = 1'b0;
    exp_rd_q.push_back(8'h50);
    exp_err_q.push_back(8'd16);
    exp_tx_q.push_back(8'hEE);
    send_byte(8'h80);
    send_byte(8'h50);
    send_byte(8'h01);
    wait_idle("timeout_idle", 100);
    rf_respond = 1'b1;

    // Illegal opcode is consumed, decoder stays idle.
    exp_err_q.push_back(8'd0);
    send_byte(8'hC0);
    check("illegal_stays_idle", state_dbg, 3'd0);

    // Length 0 means 256 writes; address wraps FE, FF, 00, ...
    for (int i = 0; i < 256; i++) begin
      a = 8'hFE + 8'(i);
      d = 8'(i) ^ 8'h5A;
      exp_wr_q.push_back({a, d});
    end
    send_byte(8'h41);
    send_byte(8'hFE);
    send_byte(8'h00);
    check("len0_cnt_loaded", cnt_dbg, 9'd256);
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A);
    @(negedge clk);
    check("len0_idle", busy, 0);

    // Reset after the 100th write of a 256-write command.
    for (int i = 0; i < 100; i++) exp_wr_q.push_back({8'h20 + 8'(i), 8'(i) + 8'h80});
    send_byte(8'h41);
    send_byte(8'h20);
    send_byte(8'h00);
    for (int i = 0; i < 100; i++) send_byte(8'(i) + 8'h80);
    @(negedge clk);
    res_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    check("midreset_rx_ready", bus.rx_ready, 1);
    check("midreset_busy", busy, 0);
    repeat (30) @(negedge clk);
    check("midreset_still_idle", busy, 0);

    // Recovery: fixed-address write after reset.
    exp_wr_q.push_back({8'h33, 8'h01});
    exp_wr_q.push_back({8'h33, 8'h02});
    send_byte(8'h40);
    send_byte(8'h33);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    wait_idle("fifo_write_idle", 20);

    repeat (4) @(negedge clk);
    check("left_wr", exp_wr_q.size(), 0);
    check("left_rd", exp_rd_q.size(), 0);
    check("left_tx", exp_tx_q.size(), 0);
    check("left_err", exp_err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_cmd_decoder.md
REGFILE_CMD_DECODER -- requirements
Module: regfile_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles to wait for done after a read strobe.
REQ-002 Parameter TIMEOUT_BYTE, default 8'hEE: byte returned in place of data when a read times out.
REQ-003 clk  in  1  single clock; every register in the block is clocked on its rising edge.
REQ-004 res_n  in  1  reset, asynchronous assert, active-low.
REQ-005 rx_data  in  8  command byte stream from the host interface.
REQ-006 rx_valid  in  1  rx_data is valid.
REQ-007 rx_ready  out  1  decoder accepts rx_data; a byte transfers when rx_valid && rx_ready.
REQ-008 tx_data  out  8  response byte to the host.
REQ-009 tx_valid  out  1  tx_data is valid.
REQ-010 tx_ready  in  1  host accepts; a byte transfers when tx_valid && tx_ready.
REQ-011 read  out  1  register-file read strobe, one cycle per access.
REQ-012 write  out  1  register-file write strobe, one cycle per access.
REQ-013 address  out  8  register-file address.
REQ-014 write_data  out  8  register-file write data.
REQ-015 read_data  in  8  register-file read data; valid in the cycle done=1.
REQ-016 done  in  1  register-file read acknowledge.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 err  out  1  one-cycle pulse on an illegal opcode or a read timeout.

Function
REQ-019 Command: byte0 opcode, byte1 start address, byte2 length L; L=0 means 256. A write command is then followed by L data bytes.
REQ-020 Opcode decode: [7:6]=01 is write, [7:6]=10 is read, and bit0=1 increments the address after each access (8-bit wrap, 8'hFF to 8'h00). With bit0=0 the address stays fixed, which is used for FIFO registers.
REQ-021 Any other [7:6] value: the byte is consumed, err pulses one cycle, and the FSM stays in IDLE.
REQ-022 FSM states: IDLE, ADDR, LEN, WDATA, WSTRB, RSTRB, RWAIT, RSEND.
REQ-023 Transitions are IDLE to ADDR to LEN on byte accept. LEN goes to WDATA for a write and to RSTRB for a read.
REQ-024 A 9-bit counter cnt loads 256 when L=0, otherwise L, on LEN accept.
REQ-025 rx_ready=1 only in IDLE, ADDR, LEN and WDATA; 0 in all other states.
REQ-026 WDATA: on accept, latch write_data and go to WSTRB.
REQ-027 WSTRB: write=1 for exactly one cycle with address and write_data stable; then decrement cnt and apply the address increment if enabled.
REQ-028 After WSTRB: cnt=0 goes to IDLE, otherwise back to WDATA. Minimum spacing between write strobes is 2 cycles.
REQ-029 RSTRB: read=1 for exactly one cycle; go to RWAIT and clear the timeout counter.
REQ-030 RWAIT, done=1: capture read_data into tx_data and go to RSEND; done is sampled from the cycle after the read strobe onward.
REQ-031 RWAIT, no done for TIMEOUT_CYCLES cycles: tx_data=TIMEOUT_BYTE, err pulses one cycle, go to RSEND.
REQ-032 RSEND: tx_valid=1 and tx_data held stable until tx_ready.
REQ-033 On transfer in RSEND: decrement cnt and increment the address if enabled. cnt=0 then goes to IDLE, otherwise to RSTRB.
REQ-034 No read strobe is issued while a response byte is pending, so exactly one register-file read occurs per returned byte and FIFO pops are never lost.
REQ-035 read and write are never asserted in the same cycle.
REQ-036 done arriving outside RWAIT is ignored.
REQ-037 tx_valid=1 only in RSEND.
REQ-038 rx_valid low mid-command: the FSM waits indefinitely in the current receive state; there is no command timeout.

Reset
REQ-039 res_n=0 forces IDLE immediately, regardless of the clock.
REQ-040 Reset values: rx_ready=0 while res_n=0 and 1 from the first clock after release; tx_valid=0, read=0, write=0, busy=0, err=0, address=0, write_data=0, tx_data=0, cnt=0.
REQ-041 Reset mid-command discards all partial command and response state. No strobe is issued during or after reset until a new full header has been received.

Verification
REQ-042 Write: rx 0x41,0x10,0x02,0xAA,0xBB -> write pulses with (addr 0x10, data 0xAA) then (0x11, 0xBB); 2 cycles apart; busy falls after the second pulse.
REQ-043 Burst read to a FIFO register: rx 0x80,0x18,0x03; done returns 0x01,0x02,0x03 one cycle after each read -> exactly 3 read pulses, all at address 0x18; tx 0x01,0x02,0x03 in order.
REQ-044 tx backpressure: same read as REQ-043 with tx_ready held 0 for 20 cycles -> one read pulse only, tx_data stable throughout; the next read comes only after the transfer.
REQ-045 Read timeout: rx 0x80,0x50,0x01 with done never asserted -> one err pulse 16 cycles after the read strobe; tx 0xEE; return to IDLE.
REQ-046 Corner cases:
- Illegal opcode 0xC0, then length 0 (0x41,0xFE,0x00 plus 256 bytes) -> err pulses once for 0xC0; 256 write pulses, address wrapping 0xFE, 0xFF, 0x00, ...
- res_n low after the 100th write -> no further strobes; busy=0.
